// File: rtl/mm_sched_pkg.sv
// Shared types and defaults for the matrix-multiplier job scheduler.
package mm_sched_pkg;

    localparam int DIM_DEF     = 16;
    localparam int WIDTH_DEF   = 4;
    localparam int NREQ_DEF    = 4;
    localparam int TIMEOUT_DEF = 4096;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    typedef logic [DIM_DEF-1:0][DIM_DEF-1:0][WIDTH_DEF-1:0]   mat_in_t;
    typedef logic [DIM_DEF-1:0][DIM_DEF-1:0][2*WIDTH_DEF-1:0] mat_out_t;

    // Increment with wrap at n; n need not be a power of two.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mm_job_scheduler_if.sv
// Requester/consumer side of the scheduler: job requests in, results out.
interface mm_job_scheduler_if
    import mm_sched_pkg::*;
#(
    parameter int DIM   = DIM_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREQ  = NREQ_DEF
);
    localparam int IDX_W     = $clog2(NREQ);
    localparam int MAT_IN_W  = DIM * DIM * WIDTH;
    localparam int MAT_OUT_W = DIM * DIM * 2 * WIDTH;

    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*MAT_IN_W-1:0] req_a;
    logic [NREQ*MAT_IN_W-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [IDX_W-1:0]         rsp_id;
    logic                     rsp_err;
    logic [MAT_OUT_W-1:0]     rsp_data;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_err, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_err, rsp_data
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at NREQ.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    int               sum;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        sum       = 0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = int'(ptr) + k;
            if (sum >= NREQ) sum = sum - NREQ;
            idx = IDX_W'(sum);
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mm_job_scheduler.sv
// Shares one accumulate-from-reset matrix multiplier among NREQ requesters;
// each job is started by pulsing the multiplier's reset for one cycle.
module mm_job_scheduler
    import mm_sched_pkg::*;
#(
    parameter int DIM     = DIM_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int NREQ    = NREQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                         clk,
    input  logic                         reset_n,
    mm_job_scheduler_if.slave            jobs,
    output logic                         mul_rst_n,
    output logic [DIM*DIM*WIDTH-1:0]     mul_a,
    output logic [DIM*DIM*WIDTH-1:0]     mul_b,
    input  logic                         mul_finished,
    input  logic [DIM*DIM*2*WIDTH-1:0]   mul_out,
    output logic                         busy
);

    // state | meaning
    // IDLE  | arbitrate, grant one-hot via req_ready
    // CLEAR | one-cycle multiplier reset pulse
    // RUN   | wait for mul_finished (masked at run_cnt 0) or timeout
    // RESP  | hold result until rsp_ready

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int MI    = DIM * DIM * WIDTH;
    localparam int MO    = DIM * DIM * 2 * WIDTH;

    sched_state_t     state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, owner_q, grant_idx;
    logic [NREQ-1:0]  grant;
    logic             any;
    logic [CNT_W-1:0] run_cnt_q;
    logic [MO-1:0]    rsp_data_q;
    logic             rsp_err_q;
    logic [MI-1:0]    mul_a_q, mul_b_q;
    logic             accept, clear_pulse, finish, timeout;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req       (jobs.req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    // A completion seen in the first RUN cycle belongs to the previous job.
    assign finish  = mul_finished && (run_cnt_q != '0);
    assign timeout = (run_cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d        = state_q;
        jobs.req_ready = '0;
        jobs.rsp_valid = 1'b0;
        accept         = 1'b0;
        clear_pulse    = 1'b0;
        busy           = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (reset_n) begin
                    jobs.req_ready = grant;
                    if (any) begin
                        accept  = 1'b1;
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: begin
                clear_pulse = 1'b1;
                state_d     = RUN;
            end
            RUN: begin
                if (finish || timeout) state_d = RESP;
            end
            RESP: begin
                jobs.rsp_valid = 1'b1;
                if (jobs.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            run_cnt_q  <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
        end else begin
            if (accept) begin
                mul_a_q  <= jobs.req_a[grant_idx*MI +: MI];
                mul_b_q  <= jobs.req_b[grant_idx*MI +: MI];
                owner_q  <= grant_idx;
                rr_ptr_q <= IDX_W'(wrap_inc(int'(grant_idx), NREQ));
            end
            if (state_q == CLEAR) begin
                run_cnt_q <= '0;
            end else if (state_q == RUN) begin
                run_cnt_q <= run_cnt_q + CNT_W'(1);
                if (finish) begin
                    rsp_data_q <= mul_out;
                    rsp_err_q  <= 1'b0;
                end else if (timeout) begin
                    rsp_err_q  <= 1'b1;
                end
            end
        end
    end

    assign mul_rst_n     = reset_n & ~clear_pulse;
    assign mul_a         = mul_a_q;
    assign mul_b         = mul_b_q;
    assign jobs.rsp_id   = owner_q;
    assign jobs.rsp_err  = rsp_err_q;
    assign jobs.rsp_data = rsp_data_q;

endmodule

// File: tb/tb_mm_job_scheduler.sv
// Bench for mm_job_scheduler with a countdown multiplier stub.
module tb_mm_job_scheduler;

    localparam int DIM     = 2;
    localparam int WIDTH   = 4;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;
    localparam int MI      = DIM * DIM * WIDTH;
    localparam int MO      = DIM * DIM * 2 * WIDTH;

    logic          clk;
    logic          reset_n;
    logic          mul_rst_n;
    logic [MI-1:0] mul_a, mul_b;
    logic          mul_finished;
    logic [MO-1:0] mul_out;
    logic          busy;

    mm_job_scheduler_if #(.DIM(DIM), .WIDTH(WIDTH), .NREQ(NREQ)) jobs ();

    mm_job_scheduler #(
        .DIM     (DIM),
        .WIDTH   (WIDTH),
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .jobs         (jobs),
        .mul_rst_n    (mul_rst_n),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_finished (mul_finished),
        .mul_out      (mul_out),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier stub: finished N cycles after mul_rst_n rises, constant data.
    int         stub_n;
    int         stub_cnt = 0;
    logic [7:0] stub_val;
    logic       force_fin;

    always @(posedge clk) begin
        if (!mul_rst_n)         stub_cnt <= 0;
        else if (stub_cnt < 1000) stub_cnt <= stub_cnt + 1;
    end
    assign mul_finished = force_fin || (stub_cnt >= stub_n);
    assign mul_out      = {4{stub_val}};

    int checks   = 0;
    int failures = 0;

    logic [MI-1:0] ra [NREQ];
    logic [MI-1:0] rb [NREQ];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic load_operands();
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = MI'($urandom);
            rb[i] = MI'($urandom);
        end
        jobs.req_a = {ra[3], ra[2], ra[1], ra[0]};
        jobs.req_b = {rb[3], rb[2], rb[1], rb[0]};
    endtask

    // Starts at negedge+1 in IDLE; returns at negedge+1 of the first rsp_valid cycle.
    task automatic run_job(input logic [3:0] req, input int n, input logic [7:0] val,
                           input logic rdy, output int owner, output int lat);
        int         waitc;
        logic [3:0] acc;
        owner = -1;
        lat   = -1;
        load_operands();
        jobs.req_valid = req;
        jobs.rsp_ready = rdy;
        stub_n   = n;
        stub_val = val;
        #1;
        waitc = 0;
        while ((jobs.req_ready & jobs.req_valid) == 4'b0 && waitc < 20) begin
            @(negedge clk); #1;
            waitc++;
        end
        acc = jobs.req_ready & jobs.req_valid;
        chk("grant_onehot", 64'($countones(jobs.req_ready)), 64'd1);
        for (int i = 0; i < NREQ; i++) if (acc[i]) owner = i;
        @(negedge clk); #1;
        jobs.req_valid = '0;
        chk("clear_low", mul_rst_n, 1'b0);
        if (owner >= 0) begin
            chk("mul_a_latch", mul_a, ra[owner]);
            chk("mul_b_latch", mul_b, rb[owner]);
        end
        @(negedge clk); #1;
        chk("clear_one_cycle", mul_rst_n, 1'b1);
        lat = 2;
        while (!jobs.rsp_valid && lat < 40) begin
            @(negedge clk); #1;
            lat++;
        end
        if (!jobs.rsp_valid) lat = -1;
    endtask

    typedef struct {
        logic [3:0] req;
        int         n;
        logic [7:0] val;
        int         exp_owner;
        logic       exp_err;
        int         exp_lat;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int            owner, lat, bad, cyc, t_acc, t_rsp, neff, mptr, m_owner, n;
        logic [7:0]    m_last, m_val;
        logic          m_busy, m_err;
        logic [3:0]    pend, exp_g;
        logic [MI-1:0] m_a;
        logic [MO-1:0] held_data;
        logic [1:0]    held_id;

        // accept->rsp_valid latency: 3+max(n,1) on finish, 2+TIMEOUT on timeout
        vecs[0]  = '{4'b0001,  5, 8'h5A, 0, 1'b0,  8, 8'h5A};
        vecs[1]  = '{4'b1111,  3, 8'h11, 1, 1'b0,  6, 8'h11};
        vecs[2]  = '{4'b1111,  1, 8'h22, 2, 1'b0,  4, 8'h22};
        vecs[3]  = '{4'b1111, 15, 8'h33, 3, 1'b0, 18, 8'h33};
        vecs[4]  = '{4'b1111, 40, 8'h44, 0, 1'b1, 18, 8'h33};
        vecs[5]  = '{4'b0001,  2, 8'h55, 0, 1'b0,  5, 8'h55};
        vecs[6]  = '{4'b1000,  4, 8'h66, 3, 1'b0,  7, 8'h66};
        vecs[7]  = '{4'b0110,  6, 8'h77, 1, 1'b0,  9, 8'h77};
        vecs[8]  = '{4'b0110,  1, 8'h88, 2, 1'b0,  4, 8'h88};
        vecs[9]  = '{4'b0011, 14, 8'h99, 0, 1'b0, 17, 8'h99};
        vecs[10] = '{4'b0100,  0, 8'hAB, 2, 1'b0,  4, 8'hAB};
        vecs[11] = '{4'b1111, 16, 8'hBC, 3, 1'b1, 18, 8'hAB};

        reset_n        = 1'b0;
        jobs.req_valid = '0;
        jobs.rsp_ready = 1'b0;
        jobs.req_a     = '0;
        jobs.req_b     = '0;
        force_fin      = 1'b0;
        stub_n         = 5000;
        stub_val       = 8'h00;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", jobs.req_ready, 4'b0);
        chk("rst_rsp_valid", jobs.rsp_valid, 1'b0);
        chk("rst_rsp_err", jobs.rsp_err, 1'b0);
        chk("rst_rsp_id", jobs.rsp_id, 2'd0);
        chk("rst_rsp_data", jobs.rsp_data, '0);
        chk("rst_mul_a", mul_a, '0);
        chk("rst_mul_b", mul_b, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mul_rst_n", mul_rst_n, 1'b0);
        reset_n = 1'b1;
        #1;
        chk("rel_mul_rst_n", mul_rst_n, 1'b1);
        @(negedge clk); #1;

        for (int r = 0; r < 12; r++) begin
            run_job(vecs[r].req, vecs[r].n, vecs[r].val, 1'b1, owner, lat);
            chk($sformatf("row%0d_owner", r), 64'(owner), 64'(vecs[r].exp_owner));
            chk($sformatf("row%0d_latency", r), 64'(lat), 64'(vecs[r].exp_lat));
            chk($sformatf("row%0d_rsp_id", r), jobs.rsp_id, 64'(vecs[r].exp_owner));
            chk($sformatf("row%0d_rsp_err", r), jobs.rsp_err, vecs[r].exp_err);
            chk($sformatf("row%0d_rsp_data", r), jobs.rsp_data, {4{vecs[r].exp_byte}});
            @(negedge clk); #1;
            chk($sformatf("row%0d_idle_busy", r), busy, 1'b0);
            chk($sformatf("row%0d_idle_rsp_valid", r), jobs.rsp_valid, 1'b0);
        end

        // Backpressure: hold RESP for 10 cycles while others request.
        run_job(4'b0100, 3, 8'hC3, 1'b0, owner, lat);
        chk("bp_owner", 64'(owner), 64'd2);
        chk("bp_latency", 64'(lat), 64'd6);
        held_data = jobs.rsp_data;
        held_id   = jobs.rsp_id;
        chk("bp_data", held_data, {4{8'hC3}});
        jobs.req_valid = 4'b1111;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (!jobs.rsp_valid || jobs.rsp_data !== held_data || jobs.rsp_id !== held_id ||
                jobs.req_ready !== 4'b0) bad++;
        end
        chk("bp_stable", 64'(bad), 64'd0);
        jobs.rsp_ready = 1'b1;
        #1;
        chk("bp_no_grant_in_handshake", jobs.req_ready, 4'b0);
        @(negedge clk); #1;
        chk("bp_released", jobs.rsp_valid, 1'b0);
        chk("bp_next_grant_rr", jobs.req_ready, 4'b1000);
        jobs.req_valid = '0;
        @(negedge clk); #1;

        // Stale finish held through CLEAR and first RUN cycle.
        load_operands();
        force_fin      = 1'b1;
        stub_n         = 5000;
        stub_val       = 8'hD4;
        jobs.req_valid = 4'b1000;
        #1;
        chk("stale_grant", jobs.req_ready, 4'b1000);
        @(negedge clk); #1;
        jobs.req_valid = '0;
        chk("stale_clear", mul_rst_n, 1'b0);
        @(negedge clk); #1;
        chk("stale_run0", jobs.rsp_valid, 1'b0);
        @(negedge clk); #1;
        chk("stale_run1", jobs.rsp_valid, 1'b0);
        @(negedge clk); #1;
        force_fin = 1'b0;
        chk("stale_captured", jobs.rsp_valid, 1'b1);
        chk("stale_data", jobs.rsp_data, {4{8'hD4}});
        chk("stale_err", jobs.rsp_err, 1'b0);
        @(negedge clk); #1;

        // Timeout job leaves err/id/data non-zero, then a job is reset mid-RUN.
        run_job(4'b0010, 5000, 8'hF1, 1'b1, owner, lat);
        chk("to_owner", 64'(owner), 64'd1);
        chk("to_latency", 64'(lat), 64'd18);
        chk("to_err", jobs.rsp_err, 1'b1);
        chk("to_data_kept", jobs.rsp_data, {4{8'hD4}});
        @(negedge clk); #1;
        load_operands();
        jobs.req_valid = 4'b0100;
        #1;
        chk("mr_grant", jobs.req_ready, 4'b0100);
        @(negedge clk); #1;
        jobs.req_valid = '0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("mr_in_run", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("mr_busy", busy, 1'b0);
        chk("mr_rsp_err", jobs.rsp_err, 1'b0);
        chk("mr_rsp_id", jobs.rsp_id, 2'd0);
        chk("mr_rsp_data", jobs.rsp_data, '0);
        chk("mr_mul_a", mul_a, '0);
        chk("mr_mul_rst_n", mul_rst_n, 1'b0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk); #1;
            if (jobs.rsp_valid || busy) bad++;
        end
        chk("mr_job_dropped", 64'(bad), 64'd0);
        run_job(4'b1111, 2, 8'hE5, 1'b1, owner, lat);
        chk("mr_ptr_reset", 64'(owner), 64'd0);
        chk("mr_next_latency", 64'(lat), 64'd5);
        chk("mr_next_data", jobs.rsp_data, {4{8'hE5}});
        @(negedge clk); #1;

        // Randomized traffic against a job-level reference model.
        m_last  = 8'hE5;
        mptr    = 1;
        m_busy  = 1'b0;
        m_err   = 1'b0;
        m_owner = 0;
        m_a     = '0;
        pend    = '0;
        t_acc   = 0;
        t_rsp   = 0;
        cyc     = 0;
        for (int it = 0; it < 1500; it++) begin
            @(negedge clk); #1;
            cyc++;
            for (int i = 0; i < NREQ; i++)
                if (!pend[i] && $urandom_range(3) == 0) pend[i] = 1'b1;
            jobs.req_valid = pend;
            jobs.rsp_ready = ($urandom_range(2) != 0);
            load_operands();
            #1;
            if (!m_busy) begin
                exp_g = '0;
                for (int k = 0; k < NREQ; k++) begin
                    if (exp_g == '0 && pend[(mptr + k) % NREQ]) begin
                        exp_g[(mptr + k) % NREQ] = 1'b1;
                        m_owner = (mptr + k) % NREQ;
                    end
                end
                chk("rand_grant", jobs.req_ready, exp_g);
                chk("rand_idle_rsp", jobs.rsp_valid, 1'b0);
                if (exp_g != '0) begin
                    m_busy   = 1'b1;
                    t_acc    = cyc;
                    n        = int'($urandom_range(0, 19));
                    m_val    = 8'($urandom);
                    stub_n   = n;
                    stub_val = m_val;
                    neff     = (n < 1) ? 1 : n;
                    if (neff <= TIMEOUT - 1) begin
                        t_rsp  = cyc + 3 + neff;
                        m_err  = 1'b0;
                        m_last = m_val;
                    end else begin
                        t_rsp = cyc + 2 + TIMEOUT;
                        m_err = 1'b1;
                    end
                    m_a   = ra[m_owner];
                    mptr  = (m_owner + 1) % NREQ;
                    pend[m_owner] = 1'b0;
                end
            end else begin
                chk("rand_busy_no_grant", jobs.req_ready, 4'b0);
                if (cyc == t_acc + 1) chk("rand_mul_a", mul_a, m_a);
                if (cyc < t_rsp) begin
                    chk("rand_rsp_early", jobs.rsp_valid, 1'b0);
                end else begin
                    chk("rand_rsp_valid", jobs.rsp_valid, 1'b1);
                    chk("rand_rsp_id", jobs.rsp_id, 64'(m_owner));
                    chk("rand_rsp_err", jobs.rsp_err, m_err);
                    chk("rand_rsp_data", jobs.rsp_data, {4{m_last}});
                    if (jobs.rsp_ready) m_busy = 1'b0;
                    if (cyc > t_rsp + 200) begin
                        $display("FAIL rand_stuck: actual=resp_not_released required=released");
                        failures++;
                        break;
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
